// File: rtl/seq_scan_ctrl.sv
// Word-to-bit-serial scan controller with an overlapping pattern matcher.
// Accepts a word, scans it MSB-first, then reports the per-word and running hit counts.
module seq_scan_ctrl #(
    parameter int                WORD_W = 8,
    parameter int                PAT_W  = 4,
    parameter logic [PAT_W-1:0]  PAT    = 4'b1101,
    parameter int                CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_word,
    input  logic                         flush,
    output logic                         serial_bit,
    output logic                         serial_vld,
    output logic                         hit,
    output logic                         word_done,
    output logic [$clog2(WORD_W+1)-1:0]  word_hits,
    output logic [CNT_W-1:0]             total_hits,
    output logic                         busy
);

    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FW = $clog2(PAT_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
    localparam logic [FW-1:0] FMAX = FW'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [WORD_W-1:0]   shift_reg;
    logic [CW-1:0]       bit_cnt;
    logic [PAT_W-2:0]    hist;
    logic [FW-1:0]       fill;
    logic [PAT_W-1:0]    win;
    logic                match;

    assign serial_bit = shift_reg[WORD_W-1];
    assign serial_vld = (state == SHIFT);
    assign in_ready   = (state == IDLE);
    assign word_done  = (state == REPORT);
    assign busy       = (state != IDLE);

    // Window of prior bits plus the bit on the wire this cycle
    assign win   = {hist, serial_bit};
    assign match = (state == SHIFT) && (win == PAT) && (fill == FMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = SHIFT;
            SHIFT:   if (bit_cnt == LAST) state_n = REPORT;
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            hist       <= '0;
            fill       <= '0;
            hit        <= 1'b0;
            word_hits  <= '0;
            total_hits <= '0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush lands before the first bit of a same-cycle word
                    if (flush) begin
                        hist <= '0;
                        fill <= '0;
                    end
                    if (in_valid) begin
                        shift_reg <= in_word;
                        bit_cnt   <= '0;
                        word_hits <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    hist      <= win[PAT_W-2:0];
                    if (fill != FMAX) fill <= fill + 1'b1;
                    if (match) begin
                        hit       <= 1'b1;
                        word_hits <= word_hits + 1'b1;
                        if (total_hits != '1) total_hits <= total_hits + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl; a second instance with CNT_W=2
// shares the inputs to exercise total_hits saturation.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_word = 8'h00;
    logic       flush = 1'b0;

    logic       in_ready, serial_bit, serial_vld, hit, word_done, busy;
    logic [3:0] word_hits;
    logic [7:0] total_hits;

    logic       s_in_ready, s_serial_bit, s_serial_vld, s_hit, s_word_done, s_busy;
    logic [3:0] s_word_hits;
    logic [1:0] s_total_hits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .flush(flush), .serial_bit(serial_bit),
        .serial_vld(serial_vld), .hit(hit), .word_done(word_done),
        .word_hits(word_hits), .total_hits(total_hits), .busy(busy)
    );

    seq_scan_ctrl #(.CNT_W(2)) sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_word(in_word), .flush(flush), .serial_bit(s_serial_bit),
        .serial_vld(s_serial_vld), .hit(s_hit), .word_done(s_word_done),
        .word_hits(s_word_hits), .total_hits(s_total_hits), .busy(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept w in cycle 0, observe cycles 1..9, return in cycle 10.
    task automatic send_word(input logic [7:0] w, input logic fl,
                             input logic fl_mid,
                             output logic [7:0] bits, output logic [9:0] hv,
                             output logic [9:0] dv, output logic [3:0] wh);
        in_valid = 1'b1;
        in_word  = w;
        flush    = fl;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_word  = ~w;
        bits = '0; hv = '0; dv = '0; wh = '0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) bits[8-c] = serial_bit;
            hv[c] = hit;
            dv[c] = word_done;
            if (c == 9) wh = word_hits;
            flush = fl_mid && (c == 3);
            step();
        end
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] o;
        rst = 1'b1;
        in_valid = 1'b1;
        in_word = 8'hFF;
        step();
        step();
        o = {hit, word_done, serial_vld, serial_bit, busy, 3'b000};
        checks++;
        if (o !== 8'h00 || word_hits !== 4'd0 || total_hits !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b wh=%0d th=%0d, need all 0",
                     o, word_hits, total_hits);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b in_ready=%b, need 0/1",
                     busy, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b; logic [9:0] hv, dv; logic [3:0] wh;
        do_reset();
        send_word(8'b11011011, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (b !== 8'b11011011) begin
            errors++;
            $display("FAIL basic_bits: got %b need 11011011", b);
        end
        checks++;
        if (hv !== 10'b0100100000) begin
            errors++;
            $display("FAIL basic_hit_cycles: got %b need 0100100000", hv);
        end
        checks++;
        if (dv !== 10'b1000000000) begin
            errors++;
            $display("FAIL basic_done_cycle: got %b need 1000000000", dv);
        end
        checks++;
        if (wh !== 4'd2 || total_hits !== 8'd2) begin
            errors++;
            $display("FAIL basic_counts: got wh=%0d th=%0d need 2/2", wh, total_hits);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_c10: got in_ready=%b busy=%b need 1/0",
                     in_ready, busy);
        end
    endtask

    task automatic test_cross_word();
        logic [7:0] b; logic [9:0] hv, dv; logic [3:0] wh;
        do_reset();
        send_word(8'b00000011, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd0) begin
            errors++;
            $display("FAIL cross_first: got wh=%0d need 0", wh);
        end
        send_word(8'b01000000, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd1 || hv !== 10'b0000001000) begin
            errors++;
            $display("FAIL cross_second: got wh=%0d hv=%b need 1/0000001000", wh, hv);
        end
        do_reset();
        send_word(8'b00000011, 1'b0, 1'b0, b, hv, dv, wh);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send_word(8'b01000000, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd0 || total_hits !== 8'd0) begin
            errors++;
            $display("FAIL cross_flush: got wh=%0d th=%0d need 0/0", wh, total_hits);
        end
        send_word(8'b00000011, 1'b0, 1'b0, b, hv, dv, wh);
        send_word(8'b01000000, 1'b1, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd0) begin
            errors++;
            $display("FAIL cross_flush_same_cycle: got wh=%0d need 0", wh);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, bw, got;
        int rdy_bad;
        a  = 8'b10110010;
        bw = 8'b11100101;
        rdy_bad = 0;
        do_reset();
        in_valid = 1'b1;
        in_word = a;
        step();
        in_word = bw;
        got = '0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) got[8-c] = serial_bit;
            if (in_ready !== 1'b0) rdy_bad++;
            step();
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL b2b_ready_low: got %0d cycles with in_ready!=0, need 0", rdy_bad);
        end
        checks++;
        if (got !== a) begin
            errors++;
            $display("FAIL b2b_first_bits: got %b need %b", got, a);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_c10: got %b need 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_word = ~bw;
        got = '0;
        for (int c = 1; c <= 8; c++) begin
            got[8-c] = serial_bit;
            if (c == 4) in_word = 8'h5A;
            step();
        end
        checks++;
        if (got !== bw) begin
            errors++;
            $display("FAIL b2b_second_bits: got %b need %b", got, bw);
        end
        step();
        step();
    endtask

    task automatic test_saturation();
        logic [7:0] b; logic [9:0] hv, dv; logic [3:0] wh;
        logic [3:0] swh1, swh2;
        logic [1:0] st1;
        do_reset();
        send_word(8'b11011011, 1'b0, 1'b0, b, hv, dv, wh);
        swh1 = s_word_hits;
        st1 = s_total_hits;
        send_word(8'b11011011, 1'b0, 1'b0, b, hv, dv, wh);
        swh2 = s_word_hits;
        checks++;
        if (st1 !== 2'd2 || s_total_hits !== 2'd3) begin
            errors++;
            $display("FAIL sat_total: got %0d then %0d need 2 then 3", st1, s_total_hits);
        end
        checks++;
        if (swh1 !== 4'd2 || swh2 !== 4'd2) begin
            errors++;
            $display("FAIL sat_word_hits: got %0d,%0d need 2,2", swh1, swh2);
        end
        checks++;
        if (total_hits !== 8'd4) begin
            errors++;
            $display("FAIL wide_total: got %0d need 4", total_hits);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] b; logic [9:0] hv, dv; logic [3:0] wh;
        int done_seen;
        do_reset();
        in_valid = 1'b1;
        in_word = 8'b11011011;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || word_done !== 1'b0 || total_hits !== 8'd0
            || serial_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got busy=%b done=%b th=%0d vld=%b need 0/0/0/0",
                     busy, word_done, total_hits, serial_vld);
        end
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (word_done === 1'b1) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: got %0d strobes need 0", done_seen);
        end
        send_word(8'b11010000, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd1 || hv !== 10'b0000100000) begin
            errors++;
            $display("FAIL rst_mid_next: got wh=%0d hv=%b need 1/0000100000", wh, hv);
        end
    endtask

    task automatic test_flush_in_shift();
        logic [7:0] b; logic [9:0] hv, dv; logic [3:0] wh;
        do_reset();
        send_word(8'b00000011, 1'b0, 1'b1, b, hv, dv, wh);
        send_word(8'b01000000, 1'b0, 1'b0, b, hv, dv, wh);
        checks++;
        if (wh !== 4'd1) begin
            errors++;
            $display("FAIL flush_shift_ignored: got wh=%0d need 1", wh);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_word();
        test_back_to_back();
        test_saturation();
        test_reset_mid_shift();
        test_flush_in_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
